// File: rtl/digit_counter_if.sv
// digit_counter_if: control, load and status bundle of a digit_counter.
// master drives controls and load data; slave returns the count and flags.
interface digit_counter_if #(
  parameter int DIGITS = 4,
  parameter int DW     = 4
);
  logic                 en;
  logic                 up;
  logic                 load;
  logic [DIGITS*DW-1:0] load_val;
  logic [DIGITS*DW-1:0] count;
  logic                 cout;
  logic                 at_zero;
  logic                 at_max;

  modport master (
    output en, up, load, load_val,
    input  count, cout, at_zero, at_max
  );

  modport slave (
    input  en, up, load, load_val,
    output count, cout, at_zero, at_max
  );
endinterface

// File: rtl/digit_counter.sv
// digit_counter: cascaded modulo-BASE up/down counter with parallel load and terminal flags.
// Define DIGIT_COUNTER_SAT_EN to hold at all-(BASE-1) / all-0 instead of wrapping.
module digit_counter #(
  parameter int DIGITS = 4,
  parameter int BASE   = 10,
  parameter int DW     = 4
) (
  input logic            clk,
  input logic            reset,
  digit_counter_if.slave bus
);
  localparam logic [DW-1:0] MAX_D  = DW'(BASE - 1);
  localparam logic [DW-1:0] ZERO_D = DW'(0);
  localparam logic [DW-1:0] ONE_D  = DW'(1);

  logic [DW-1:0] digit_r     [DIGITS];
  logic [DW-1:0] stepped_s   [DIGITS];
  logic [DW-1:0] digit_nxt_s [DIGITS];
  logic          cout_r;
  logic          cout_nxt_s;
  logic          all_zero_s;
  logic          all_max_s;
  logic          wrap_s;

  function automatic logic [DW-1:0] step_digit(input logic [DW-1:0] d, input logic dir);
    logic [DW-1:0] r;
    if (dir) begin
      r = (d == MAX_D) ? ZERO_D : d + ONE_D;
    end else begin
      r = (d == ZERO_D) ? MAX_D : d - ONE_D;
    end
    return r;
  endfunction

  // Out-of-range load digits collapse to 0 so the state never leaves 0..BASE-1.
  function automatic logic [DW-1:0] sanitize_digit(input logic [DW-1:0] d);
    return (d > MAX_D) ? ZERO_D : d;
  endfunction

  // Terminal detection across all digits; wrap_s is the terminal value for the current direction.
  always_comb begin
    all_zero_s = 1'b1;
    all_max_s  = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      all_zero_s = all_zero_s & (digit_r[i] == ZERO_D);
      all_max_s  = all_max_s  & (digit_r[i] == MAX_D);
    end
    wrap_s = bus.up ? all_max_s : all_zero_s;
  end

  // Ripple enable: digit i steps only when every lower digit is at its terminal value.
  always_comb begin
    logic ripple;
    ripple = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      stepped_s[i] = ripple ? step_digit(digit_r[i], bus.up) : digit_r[i];
      ripple       = ripple & (bus.up ? (digit_r[i] == MAX_D) : (digit_r[i] == ZERO_D));
    end
  end

  // Next-state selection: load beats count enable, otherwise hold.
  always_comb begin
    for (int i = 0; i < DIGITS; i++) begin
      digit_nxt_s[i] = digit_r[i];
    end
    cout_nxt_s = 1'b0;
    if (bus.load) begin
      for (int i = 0; i < DIGITS; i++) begin
        digit_nxt_s[i] = sanitize_digit(bus.load_val[i*DW +: DW]);
      end
    end else if (bus.en) begin
`ifdef DIGIT_COUNTER_SAT_EN
      if (!wrap_s) begin
        for (int i = 0; i < DIGITS; i++) begin
          digit_nxt_s[i] = stepped_s[i];
        end
      end else begin
        cout_nxt_s = 1'b0;
      end
`else
      for (int i = 0; i < DIGITS; i++) begin
        digit_nxt_s[i] = stepped_s[i];
      end
      cout_nxt_s = wrap_s;
`endif
    end else begin
      cout_nxt_s = 1'b0;
    end
  end

  // State register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < DIGITS; i++) begin
        digit_r[i] <= ZERO_D;
      end
      cout_r <= 1'b0;
    end else begin
      for (int i = 0; i < DIGITS; i++) begin
        digit_r[i] <= digit_nxt_s[i];
      end
      cout_r <= cout_nxt_s;
    end
  end

  for (genvar g = 0; g < DIGITS; g++) begin : g_pack
    assign bus.count[g*DW +: DW] = digit_r[g];
  end

  assign bus.cout    = cout_r;
  assign bus.at_zero = all_zero_s;
  assign bus.at_max  = all_max_s;
endmodule

// File: tb/tb_digit_counter.sv
// tb_digit_counter: scoreboard bench for digit_counter in three configurations
// (2x base-10, 3x base-6, 1x base-2); expectations come from an integer-value model.
module tb_digit_counter;
  logic clk = 1'b0;
  logic rst2, rst3, rst1;
  int   checks = 0;
  int   errors = 0;
  int   m2 = 0;
  int   m3 = 0;
  int   m1 = 0;

  typedef struct {
    logic [11:0] count;
    logic        cout;
    logic        az;
    logic        am;
  } exp_t;

  exp_t q2[$];
  exp_t q3[$];
  exp_t q1[$];

  always #5 clk = ~clk;

  digit_counter_if #(.DIGITS(2), .DW(4)) b2 ();
  digit_counter_if #(.DIGITS(3), .DW(3)) b3 ();
  digit_counter_if #(.DIGITS(1), .DW(1)) b1 ();

  digit_counter #(.DIGITS(2), .BASE(10), .DW(4)) u2 (.clk(clk), .reset(rst2), .bus(b2));
  digit_counter #(.DIGITS(3), .BASE(6),  .DW(3)) u3 (.clk(clk), .reset(rst3), .bus(b3));
  digit_counter #(.DIGITS(1), .BASE(2),  .DW(1)) u1 (.clk(clk), .reset(rst1), .bus(b1));

  function automatic logic [11:0] enc(input int v, input int base, input int nd, input int dw);
    logic [11:0] r;
    int          t;
    r = 12'h000;
    t = v;
    for (int i = 0; i < nd; i++) begin
      r = r | 12'((t % base) << (i * dw));
      t = t / base;
    end
    return r;
  endfunction

  function automatic int dec(input logic [11:0] lv, input int base, input int nd, input int dw);
    int v;
    int d;
    v = 0;
    for (int i = nd - 1; i >= 0; i--) begin
      d = int'((lv >> (i * dw)) & ((12'd1 << dw) - 12'd1));
      if (d >= base) d = 0;
      v = v * base + d;
    end
    return v;
  endfunction

  function automatic int model_next(input int v, input int n, input logic ld, input logic e,
                                    input logic u, input int ldv, output logic c);
    int r;
    c = 1'b0;
    r = v;
    if (ld) begin
      r = ldv;
    end else if (e && u) begin
      if (v == n - 1) begin
`ifdef DIGIT_COUNTER_SAT_EN
        r = v;
`else
        r = 0;
        c = 1'b1;
`endif
      end else begin
        r = v + 1;
      end
    end else if (e) begin
      if (v == 0) begin
`ifdef DIGIT_COUNTER_SAT_EN
        r = v;
`else
        r = n - 1;
        c = 1'b1;
`endif
      end else begin
        r = v - 1;
      end
    end
    return r;
  endfunction

  task automatic drive2(input logic rst, input logic ld, input logic e, input logic u, input logic [7:0] lv);
    logic c;
    exp_t x;
    rst2 = rst; b2.load = ld; b2.en = e; b2.up = u; b2.load_val = lv;
    c = 1'b0;
    if (!rst) m2 = 0;
    else m2 = model_next(m2, 100, ld, e, u, dec({4'h0, lv}, 10, 2, 4), c);
    x.count = enc(m2, 10, 2, 4); x.cout = c; x.az = (m2 == 0); x.am = (m2 == 99);
    q2.push_back(x);
    @(posedge clk); #1;
  endtask

  task automatic drive2v(input logic [11:0] s);
    drive2(s[11], s[10], s[9], s[8], s[7:0]);
  endtask

  task automatic drive3(input logic rst, input logic ld, input logic e, input logic u, input logic [8:0] lv);
    logic c;
    exp_t x;
    rst3 = rst; b3.load = ld; b3.en = e; b3.up = u; b3.load_val = lv;
    c = 1'b0;
    if (!rst) m3 = 0;
    else m3 = model_next(m3, 216, ld, e, u, dec({3'h0, lv}, 6, 3, 3), c);
    x.count = enc(m3, 6, 3, 3); x.cout = c; x.az = (m3 == 0); x.am = (m3 == 215);
    q3.push_back(x);
    @(posedge clk); #1;
  endtask

  task automatic drive1(input logic rst, input logic ld, input logic e, input logic u, input logic lv);
    logic c;
    exp_t x;
    rst1 = rst; b1.load = ld; b1.en = e; b1.up = u; b1.load_val = lv;
    c = 1'b0;
    if (!rst) m1 = 0;
    else m1 = model_next(m1, 2, ld, e, u, dec({11'h000, lv}, 2, 1, 1), c);
    x.count = enc(m1, 2, 1, 1); x.cout = c; x.az = (m1 == 0); x.am = (m1 == 1);
    q1.push_back(x);
    @(posedge clk); #1;
  endtask

  // Stimulus word: {reset, load, en, up, load_val}; 0xx reset, Cxx load, Bxx up, Axx down, 8xx hold.
  task automatic test_reset();
    logic [11:0] s [4] = '{12'h000, 12'h855, 12'h855, 12'h855};
    exp_t x;
    foreach (s[k]) begin
      drive2v(s[k]);
      x = q2.pop_front(); checks++;
      if (b2.count !== x.count[7:0] || b2.cout !== x.cout || b2.at_zero !== x.az || b2.at_max !== x.am) begin
        errors++;
        $display("FAIL reset_hold[%0d]: got count=%h cout=%b at_zero=%b at_max=%b, want count=%h cout=%b at_zero=%b at_max=%b",
                 k, b2.count, b2.cout, b2.at_zero, b2.at_max, x.count[7:0], x.cout, x.az, x.am);
      end
    end
  endtask

  task automatic test_cascade_up();
    logic [11:0] s [4] = '{12'hC18, 12'hB00, 12'hB00, 12'hB00};
    exp_t x;
    foreach (s[k]) begin
      drive2v(s[k]);
      x = q2.pop_front(); checks++;
      if (b2.count !== x.count[7:0] || b2.cout !== x.cout || b2.at_zero !== x.az || b2.at_max !== x.am) begin
        errors++;
        $display("FAIL cascade_up[%0d]: got count=%h cout=%b at_zero=%b at_max=%b, want count=%h cout=%b at_zero=%b at_max=%b",
                 k, b2.count, b2.cout, b2.at_zero, b2.at_max, x.count[7:0], x.cout, x.az, x.am);
      end
    end
  endtask

  task automatic test_wrap();
    logic [11:0] s [10] = '{12'hC98, 12'hB00, 12'hB00, 12'h800, 12'hC00, 12'hA00, 12'hA00, 12'h800,
                            12'hC20, 12'hA00};
    exp_t x;
    foreach (s[k]) begin
      drive2v(s[k]);
      x = q2.pop_front(); checks++;
      if (b2.count !== x.count[7:0] || b2.cout !== x.cout || b2.at_zero !== x.az || b2.at_max !== x.am) begin
        errors++;
        $display("FAIL wrap[%0d]: got count=%h cout=%b at_zero=%b at_max=%b, want count=%h cout=%b at_zero=%b at_max=%b",
                 k, b2.count, b2.cout, b2.at_zero, b2.at_max, x.count[7:0], x.cout, x.az, x.am);
      end
    end
  endtask

  task automatic test_priority();
    logic [11:0] s [8] = '{12'hF3C, 12'hB00, 12'h43C, 12'hCFF, 12'hCA7, 12'hC57, 12'h3C0, 12'hE91};
    exp_t x;
    foreach (s[k]) begin
      drive2v(s[k]);
      x = q2.pop_front(); checks++;
      if (b2.count !== x.count[7:0] || b2.cout !== x.cout || b2.at_zero !== x.az || b2.at_max !== x.am) begin
        errors++;
        $display("FAIL priority[%0d]: got count=%h cout=%b at_zero=%b at_max=%b, want count=%h cout=%b at_zero=%b at_max=%b",
                 k, b2.count, b2.cout, b2.at_zero, b2.at_max, x.count[7:0], x.cout, x.az, x.am);
      end
    end
  endtask

  task automatic test_random_mix();
    exp_t x;
    for (int k = 0; k < 80; k++) begin
      drive2($urandom_range(0, 15) != 0, $urandom_range(0, 5) == 0, $urandom_range(0, 3) != 0,
             $urandom_range(0, 1) == 1, 8'($urandom));
      x = q2.pop_front(); checks++;
      if (b2.count !== x.count[7:0] || b2.cout !== x.cout || b2.at_zero !== x.az || b2.at_max !== x.am) begin
        errors++;
        $display("FAIL random_mix[%0d]: got count=%h cout=%b at_zero=%b at_max=%b, want count=%h cout=%b at_zero=%b at_max=%b",
                 k, b2.count, b2.cout, b2.at_zero, b2.at_max, x.count[7:0], x.cout, x.az, x.am);
      end
    end
  endtask

  task automatic test_base6();
    exp_t        x;
    int          pulses;
    int          want_pulses;
    logic [8:0]  want_final;
`ifdef DIGIT_COUNTER_SAT_EN
    want_pulses = 0;
    want_final  = 9'h16D;
`else
    want_pulses = 1;
    want_final  = 9'h000;
`endif
    pulses = 0;
    drive3(1'b0, 1'b0, 1'b0, 1'b1, 9'h000);
    void'(q3.pop_front());
    for (int k = 0; k < 216; k++) begin
      drive3(1'b1, 1'b0, 1'b1, 1'b1, 9'h000);
      if (b3.cout === 1'b1) pulses++;
      x = q3.pop_front(); checks++;
      if (b3.count !== x.count[8:0] || b3.cout !== x.cout || b3.at_zero !== x.az || b3.at_max !== x.am) begin
        errors++;
        $display("FAIL base6_step[%0d]: got count=%h cout=%b at_zero=%b at_max=%b, want count=%h cout=%b at_zero=%b at_max=%b",
                 k, b3.count, b3.cout, b3.at_zero, b3.at_max, x.count[8:0], x.cout, x.az, x.am);
      end
    end
    checks++;
    if (pulses != want_pulses) begin
      errors++;
      $display("FAIL base6_pulses: got %0d cout pulses, want %0d", pulses, want_pulses);
    end
    checks++;
    if (b3.count !== want_final) begin
      errors++;
      $display("FAIL base6_final: got count=%h, want %h", b3.count, want_final);
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0] s [7] = '{4'h0, 4'hD, 4'hB, 4'hA, 4'hB, 4'hA, 4'h8};
    exp_t x;
    foreach (s[k]) begin
      drive1(s[k][3], s[k][2], s[k][1], s[k][0], 1'b1);
      x = q1.pop_front(); checks++;
      if (b1.count !== x.count[0] || b1.cout !== x.cout || b1.at_zero !== x.az || b1.at_max !== x.am) begin
        errors++;
        $display("FAIL back_to_back[%0d]: got count=%h cout=%b at_zero=%b at_max=%b, want count=%h cout=%b at_zero=%b at_max=%b",
                 k, b1.count, b1.cout, b1.at_zero, b1.at_max, x.count[0], x.cout, x.az, x.am);
      end
    end
  endtask

  initial begin
    rst2 = 1'b0; rst3 = 1'b0; rst1 = 1'b0;
    b2.en = 1'b0; b2.up = 1'b1; b2.load = 1'b0; b2.load_val = '0;
    b3.en = 1'b0; b3.up = 1'b1; b3.load = 1'b0; b3.load_val = '0;
    b1.en = 1'b0; b1.up = 1'b1; b1.load = 1'b0; b1.load_val = '0;
    test_reset();
    test_cascade_up();
    test_wrap();
    test_priority();
    test_random_mix();
    test_base6();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, limit 200000", $time);
    $fatal(1, "watchdog expired");
  end
endmodule
